ram_fifo_responder: RTL and testbench

RAM_FIFO_RESPONDER -- requirements
Module: ram_fifo_responder

---
 rtl/ram_if_pkg.sv | 29 ++
 rtl/ram_fifo_responder.sv | 143 ++++++++++++++
 tb/tb_ram_fifo_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_if_pkg.sv
// Shared RAM-interface definitions: default geometry, request-word layout and
// responder state encodings, common to the responder and the cache-side controller.
package ram_if_pkg;

    localparam int ADDR_SIZE       = 13;
    localparam int CACHE_STR_WIDTH = 64;
    localparam int WORDS_PER_LINE  = 4;
    localparam int WORD_W          = CACHE_STR_WIDTH / WORDS_PER_LINE;
    localparam int IDX_W           = 2;

    // Request word is {avalid, rnw, addr, wdata}; bit offsets counted from bit 0.
    localparam int REQ_WDATA_LSB  = 0;
    localparam int REQ_ADDR_LSB   = WORD_W;
    localparam int REQ_RNW_BIT    = WORD_W + ADDR_SIZE;
    localparam int REQ_AVALID_BIT = WORD_W + ADDR_SIZE + 1;
    localparam int REQ_W          = ADDR_SIZE + WORD_W + 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD_ISSUE = 2'd2,
        S_RD_PUSH  = 2'd3
    } resp_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ram_fifo_responder.sv
// Drains line requests from a show-ahead request FIFO, moves 4-word lines to or
// from a 1-cycle-latency RAM, and pushes read words into the response FIFO.
//
// state      | meaning
// S_IDLE     | waiting for a header; data entries here are protocol errors
// S_WR       | consuming write words, one memory write per popped entry
// S_RD_ISSUE | issuing a memory read once the response FIFO has room
// S_RD_PUSH  | forwarding the returned word to the response FIFO
module ram_fifo_responder #(
    parameter int ADDR_SIZE       = ram_if_pkg::ADDR_SIZE,
    parameter int CACHE_STR_WIDTH = ram_if_pkg::CACHE_STR_WIDTH,
    parameter int WORD_W          = CACHE_STR_WIDTH / ram_if_pkg::WORDS_PER_LINE
) (
    input  logic                        clk,
    input  logic                        not_reset,
    input  logic                        req_empty,
    input  logic [ADDR_SIZE+WORD_W+1:0] req_rdata,
    output logic                        req_read,
    input  logic                        rsp_full,
    output logic                        rsp_write,
    output logic [WORD_W-1:0]           rsp_wdata,
    output logic [ADDR_SIZE+1:0]        mem_addr,
    output logic                        mem_we,
    output logic [WORD_W-1:0]           mem_wdata,
    output logic                        mem_re,
    input  logic [WORD_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [7:0]                  err_cnt
);
    import ram_if_pkg::*;

    localparam int AVALID_BIT = WORD_W + ADDR_SIZE + 1;
    localparam int RNW_BIT    = WORD_W + ADDR_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    resp_state_t          state;
    logic [IDX_W-1:0]     idx;
    logic [ADDR_SIZE-1:0] line;

    logic                 req_avalid;
    logic                 req_rnw;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_W-1:0]    req_wdata;

    assign req_avalid = req_rdata[AVALID_BIT];
    assign req_rnw    = req_rdata[RNW_BIT];
    assign req_addr   = req_rdata[RNW_BIT-1:WORD_W];
    assign req_wdata  = req_rdata[WORD_W-1:0];

    // Address and write data are forced to zero whenever no strobe is active.
    always_comb begin
        req_read  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                req_read = !req_empty;
            end
            S_WR: begin
                if (!req_empty && !req_avalid) begin
                    req_read  = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {line, idx};
                    mem_wdata = req_wdata;
                end
            end
            S_RD_ISSUE: begin
                if (!rsp_full) begin
                    mem_re   = 1'b1;
                    mem_addr = {line, idx};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            line      <= '0;
            rsp_write <= 1'b0;
            rsp_wdata <= '0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            rsp_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!req_empty) begin
                        if (req_avalid) begin
                            line  <= req_addr;
                            idx   <= '0;
                            state <= req_rnw ? S_RD_ISSUE : S_WR;
                            busy  <= 1'b1;
                        end else begin
                            err_cnt <= sat_inc8(err_cnt);
                        end
                    end
                end
                S_WR: begin
                    if (!req_empty) begin
                        // A header mid-line aborts; it stays in the FIFO for S_IDLE to decode.
                        if (req_avalid) begin
                            err_cnt <= sat_inc8(err_cnt);
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                            if (idx == LAST_IDX) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (!rsp_full) begin
                        state <= S_RD_PUSH;
                    end
                end
                S_RD_PUSH: begin
                    rsp_write <= 1'b1;
                    rsp_wdata <= mem_rdata;
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_RD_ISSUE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_responder.sv
// Scoreboard bench for ram_fifo_responder: FIFO and RAM models, a line-level
// reference memory, directed timing scenarios and a randomized transaction mix.
module tb_ram_fifo_responder;
    import ram_if_pkg::*;

    localparam int AW = ADDR_SIZE + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 not_reset;
    logic                 req_empty;
    logic [REQ_W-1:0]     req_rdata;
    logic                 req_read;
    logic                 rsp_full;
    logic                 rsp_write;
    logic [WORD_W-1:0]    rsp_wdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic [WORD_W-1:0]    mem_wdata;
    logic                 mem_re;
    logic [WORD_W-1:0]    mem_rdata;
    logic                 busy;
    logic [7:0]           err_cnt;

    ram_fifo_responder dut (
        .clk(clk), .not_reset(not_reset),
        .req_empty(req_empty), .req_rdata(req_rdata), .req_read(req_read),
        .rsp_full(rsp_full), .rsp_write(rsp_write), .rsp_wdata(rsp_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_rdata(mem_rdata),
        .busy(busy), .err_cnt(err_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_model = 0;

    logic [REQ_W-1:0]     req_q[$];
    logic [WORD_W-1:0]    exp_rsp[$];
    logic [AW+WORD_W-1:0] exp_wr[$];
    int pop_log[$], re_log[$], we_log[$], rw_log[$], fall_log[$];

    logic [WORD_W-1:0] mem     [0:(1<<AW)-1];
    logic [WORD_W-1:0] ref_mem [0:(1<<AW)-1];

    logic                 busy_q = 1'b0;
    logic                 rand_full = 1'b0;
    logic [AW+WORD_W-1:0] wr_e;
    logic [WORD_W-1:0]    rsp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // show-ahead request FIFO
    always @(posedge clk) begin
        if (req_read && req_q.size() > 0) void'(req_q.pop_front());
        req_empty <= (req_q.size() == 0);
        req_rdata <= (req_q.size() > 0) ? req_q[0] : '0;
    end

    // external RAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    always @(posedge clk) begin
        if (rand_full) begin
            #1 rsp_full = ($urandom_range(0, 3) == 0);
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (not_reset) begin
            if (req_read) begin
                pop_log.push_back(cyc);
                check("req_read_when_empty", {31'd0, req_empty}, 32'd0);
            end
            if (mem_we || mem_re) check("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
            if (mem_re) begin
                re_log.push_back(cyc);
                check("mem_re_while_full", {31'd0, rsp_full}, 32'd0);
            end
            if (mem_we) begin
                we_log.push_back(cyc);
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_we: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
                end else begin
                    wr_e = exp_wr.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(wr_e[AW+WORD_W-1:WORD_W]));
                    check("mem_wdata", 32'(mem_wdata), 32'(wr_e[WORD_W-1:0]));
                end
            end
            if (rsp_write) begin
                rw_log.push_back(cyc);
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp_write: data 0x%0h, none expected", rsp_wdata);
                end else begin
                    rsp_e = exp_rsp.pop_front();
                    check("rsp_wdata", 32'(rsp_wdata), 32'(rsp_e));
                end
            end
            if (busy_q && !busy) fall_log.push_back(cyc);
            busy_q = busy;
        end
    end

    function automatic logic [REQ_W-1:0] mk(input logic av, input logic rnw,
                                            input logic [ADDR_SIZE-1:0] a,
                                            input logic [WORD_W-1:0] d);
        return {av, rnw, a, d};
    endfunction

    task automatic bump_err();
        err_model = (err_model < 255) ? err_model + 1 : 255;
    endtask

    task automatic push_read(input logic [ADDR_SIZE-1:0] ln);
        req_q.push_back(mk(1'b1, 1'b1, ln, WORD_W'($urandom)));
        for (int i = 0; i < 4; i++) exp_rsp.push_back(ref_mem[{ln, 2'(i)}]);
    endtask

    task automatic push_wr_hdr(input logic [ADDR_SIZE-1:0] ln);
        req_q.push_back(mk(1'b1, 1'b0, ln, WORD_W'($urandom)));
    endtask

    task automatic push_wr_word(input logic [ADDR_SIZE-1:0] ln, input int i, input logic [WORD_W-1:0] d);
        req_q.push_back(mk(1'b0, 1'($urandom), ADDR_SIZE'($urandom), d));
        exp_wr.push_back({ln, 2'(i), d});
        ref_mem[{ln, 2'(i)}] = d;
    endtask

    task automatic push_err();
        req_q.push_back(mk(1'b0, 1'($urandom), ADDR_SIZE'($urandom), WORD_W'($urandom)));
        bump_err();
    endtask

    task automatic clear_logs();
        pop_log.delete(); re_log.delete(); we_log.delete(); rw_log.delete(); fall_log.delete();
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (n < limit && !(req_q.size() == 0 && req_empty && !busy &&
                                  exp_rsp.size() == 0 && exp_wr.size() == 0));
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles (req %0d rsp %0d wr %0d)",
                     name, n, req_q.size(), exp_rsp.size(), exp_wr.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rsp_write"}, {31'd0, rsp_write}, 32'd0);
        check({tag, "_rsp_wdata"}, 32'(rsp_wdata), 32'd0);
        check({tag, "_busy"},      {31'd0, busy}, 32'd0);
        check({tag, "_err_cnt"},   32'(err_cnt), 32'd0);
        check({tag, "_req_read"},  {31'd0, req_read}, 32'd0);
        check({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_re"},    {31'd0, mem_re}, 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, base_rw, base_re, n, kind, nw;
        logic [ADDR_SIZE-1:0] ln;
        logic pend_abort;

        not_reset = 1'b0;
        rsp_full  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = WORD_W'(i * 7 + 3) ^ 16'h5A5A;
            ref_mem[i] = WORD_W'(i * 7 + 3) ^ 16'h5A5A;
        end
        mem[15'h294] = 16'h1111; ref_mem[15'h294] = 16'h1111;
        mem[15'h295] = 16'h2222; ref_mem[15'h295] = 16'h2222;
        mem[15'h296] = 16'h3333; ref_mem[15'h296] = 16'h3333;
        mem[15'h297] = 16'h4444; ref_mem[15'h297] = 16'h4444;

        repeat (3) @(negedge clk);
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        not_reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;

        // unstalled read of line 0x0A5
        clear_logs();
        push_read(13'h0A5);
        wait_idle(100, "read_a5");
        check("read_pops", pop_log.size(), 1);
        check("read_re_count", re_log.size(), 4);
        check("read_rw_count", rw_log.size(), 4);
        if (pop_log.size() == 1 && re_log.size() == 4 && rw_log.size() == 4) begin
            h = pop_log[0];
            for (int i = 0; i < 4; i++) begin
                check("read_re_cycle", re_log[i] - h, 1 + 2 * i);
                check("read_rw_cycle", rw_log[i] - h, 3 + 2 * i);
            end
            if (fall_log.size() > 0) check("read_idle_cycle", fall_log[0] - h, 9);
        end

        // unstalled write of line 0x001
        clear_logs();
        push_wr_hdr(13'h001);
        push_wr_word(13'h001, 0, 16'hA0A0);
        push_wr_word(13'h001, 1, 16'hB1B1);
        push_wr_word(13'h001, 2, 16'hC2C2);
        push_wr_word(13'h001, 3, 16'hD3D3);
        wait_idle(100, "write_001");
        check("write_we_count", we_log.size(), 4);
        if (we_log.size() == 4 && pop_log.size() > 0) begin
            h = pop_log[0];
            for (int i = 0; i < 4; i++) check("write_we_cycle", we_log[i] - h, 1 + i);
            if (fall_log.size() > 0) check("write_idle_cycle", fall_log[0] - h, 5);
        end
        push_read(13'h001);
        wait_idle(100, "readback_001");

        // write with 5-cycle request stall mid-line
        clear_logs();
        push_wr_hdr(13'h123);
        push_wr_word(13'h123, 0, 16'h0F01);
        push_wr_word(13'h123, 1, 16'h0F02);
        repeat (8) @(negedge clk);
        #2;
        push_wr_word(13'h123, 2, 16'h0F03);
        push_wr_word(13'h123, 3, 16'h0F04);
        wait_idle(100, "write_stall");
        check("stall_we_count", we_log.size(), 4);
        check("stall_re_count", re_log.size(), 0);
        if (we_log.size() == 4) begin
            check("stall_gap01", we_log[1] - we_log[0], 1);
            check("stall_gap12", we_log[2] - we_log[1], 6);
            check("stall_gap23", we_log[3] - we_log[2], 1);
        end

        // read with response FIFO full for 6 cycles
        clear_logs();
        push_read(13'h0A5);
        repeat (2) @(posedge clk);
        #1 rsp_full = 1'b1;
        repeat (6) @(posedge clk);
        #1 rsp_full = 1'b0;
        wait_idle(100, "read_full");
        check("full_re_count", re_log.size(), 4);
        check("full_rw_count", rw_log.size(), 4);
        if (re_log.size() > 0 && pop_log.size() > 0) check("full_first_re", re_log[0] - pop_log[0], 7);

        // stray data entry in idle, then a header aborting a write after 2 words
        clear_logs();
        push_err();
        push_wr_hdr(13'h050);
        push_wr_word(13'h050, 0, 16'h5150);
        push_wr_word(13'h050, 1, 16'h5151);
        bump_err();
        push_read(13'h0A5);
        wait_idle(200, "abort");
        check("abort_err_cnt", 32'(err_cnt), 32'd2);
        check("abort_we_count", we_log.size(), 2);
        check("abort_rw_count", rw_log.size(), 4);

        // randomized transaction mix
        rand_full  = 1'b1;
        pend_abort = 1'b0;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            ln   = ADDR_SIZE'($urandom_range(0, 31));
            if (kind == 0 && !pend_abort) begin
                push_err();
            end else if (kind < 5) begin
                if (pend_abort) bump_err();
                pend_abort = 1'b0;
                push_read(ln);
            end else begin
                if (pend_abort) bump_err();
                pend_abort = 1'b0;
                push_wr_hdr(ln);
                nw = (kind == 9) ? $urandom_range(1, 3) : 4;
                for (int i = 0; i < nw; i++) push_wr_word(ln, i, WORD_W'($urandom));
                if (nw < 4) pend_abort = 1'b1;
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        if (pend_abort) begin
            bump_err();
            push_read(13'h0A5);
        end
        wait_idle(4000, "random");
        rand_full = 1'b0;
        @(negedge clk);
        rsp_full = 1'b0;
        check("random_err_cnt", 32'(err_cnt), 32'(err_model));

        // reset pulse after the second response word
        wait_idle(100, "pre_reset");
        clear_logs();
        push_read(13'h0A5);
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (n < 100 && rw_log.size() < 2);
        check("reset_trigger_rw", rw_log.size(), 2);
        not_reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_rsp.delete();
        err_model = 0;
        base_rw = rw_log.size();
        base_re = re_log.size();
        repeat (3) @(negedge clk);
        not_reset = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("post_reset_rw", rw_log.size(), base_rw);
        check("post_reset_re", re_log.size(), base_re);
        check("post_reset_we", we_log.size(), 0);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        // error counter saturation
        for (int i = 0; i < 260; i++) push_err();
        wait_idle(600, "saturate");
        check("sat_err_cnt", 32'(err_cnt), 32'(err_model));

        check("exp_rsp_left", exp_rsp.size(), 0);
        check("exp_wr_left", exp_wr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
